// File: rtl/conv1d_pe_if.sv
// rtl/conv1d_pe_if.sv - handshake bundle for the conv1d_pe write channels and psum stream
//
// Purpose: groups the filter write channel, the ifmap write channel and the
// psum result stream of conv1d_pe into one interface.
//
// Signals:
//   filt_valid/filt_ready/filt_addr/filt_data     filter memory write channel
//   ifmap_valid/ifmap_ready/ifmap_addr/ifmap_data ifmap memory write channel
//   psum_valid/psum_ready/psum_data/psum_idx      result stream, one per window
//
// Modports:
//   slave  - the processing element (accepts writes, produces psums)
//   master - the environment (issues writes, consumes psums)

interface conv1d_pe_if #(
  parameter int DATA_W   = 4,
  parameter int PSUM_W   = 8,
  parameter int FILT_AW  = 2,
  parameter int IFMAP_AW = 3,
  parameter int IDX_W    = 2
);

  logic                filt_valid;
  logic                filt_ready;
  logic [FILT_AW-1:0]  filt_addr;
  logic [DATA_W-1:0]   filt_data;

  logic                ifmap_valid;
  logic                ifmap_ready;
  logic [IFMAP_AW-1:0] ifmap_addr;
  logic [DATA_W-1:0]   ifmap_data;

  logic                psum_valid;
  logic                psum_ready;
  logic [PSUM_W-1:0]   psum_data;
  logic [IDX_W-1:0]    psum_idx;

  modport slave (
    input  filt_valid, filt_addr, filt_data,
    output filt_ready,
    input  ifmap_valid, ifmap_addr, ifmap_data,
    output ifmap_ready,
    output psum_valid, psum_data, psum_idx,
    input  psum_ready
  );

  modport master (
    output filt_valid, filt_addr, filt_data,
    input  filt_ready,
    output ifmap_valid, ifmap_addr, ifmap_data,
    input  ifmap_ready,
    input  psum_valid, psum_data, psum_idx,
    output psum_ready
  );

endinterface

// File: rtl/conv1d_pe.sv
// rtl/conv1d_pe.sv - 1-D convolution processing element with saturating MAC
//
// Purpose: holds a FILT_LEN-tap filter and an IFMAP_LEN-entry ifmap in local
// registers, and on start computes N_OUT windowed dot products, one tap per
// cycle, emitting each as a psum on a valid/ready stream.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset (clears memories too)
//   start          run request, only honoured while idle
//   busy           run in progress (MAC / PSIN / EMIT)
//   done           one-cycle pulse at the end of a run
//   bus            conv1d_pe_if.slave: filter/ifmap write channels, psum stream
//   psum_in_valid  upstream psum valid        (PSUM_IN_EN only)
//   psum_in_ready  upstream psum ready        (PSUM_IN_EN only)
//   psum_in_data   upstream psum to accumulate (PSUM_IN_EN only)
//
// Configuration macro: PSUM_IN_EN - when defined, adds the psum_in stream and
// a PSIN state that folds one upstream psum into each window before emitting.

module conv1d_pe #(
  parameter int DATA_W    = 4,
  parameter int IFMAP_LEN = 5,
  parameter int FILT_LEN  = 3,
  parameter int STRIDE    = 1,
  parameter int PSUM_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
`ifdef PSUM_IN_EN
  input  logic              psum_in_valid,
  output logic              psum_in_ready,
  input  logic [PSUM_W-1:0] psum_in_data,
`endif
  conv1d_pe_if.slave        bus
);

  localparam int N_OUT    = (IFMAP_LEN - FILT_LEN) / STRIDE + 1;
  localparam int FILT_AW  = (FILT_LEN  > 1) ? $clog2(FILT_LEN)  : 1;
  localparam int IFMAP_AW = (IFMAP_LEN > 1) ? $clog2(IFMAP_LEN) : 1;
  localparam int IDX_W    = (N_OUT     > 1) ? $clog2(N_OUT)     : 1;
  localparam int PROD_W   = 2 * DATA_W;
  // One spare bit above the wider operand so the raw sum never wraps
  // before the saturation compare.
  localparam int SUM_W    = ((PSUM_W > PROD_W) ? PSUM_W : PROD_W) + 1;

  localparam logic [SUM_W-1:0]    PSUM_MAX    = {{(SUM_W-PSUM_W){1'b0}}, {PSUM_W{1'b1}}};
  localparam logic [FILT_AW:0]    FILT_DEPTH  = (FILT_AW+1)'(FILT_LEN);
  localparam logic [IFMAP_AW:0]   IFMAP_DEPTH = (IFMAP_AW+1)'(IFMAP_LEN);
  localparam logic [FILT_AW-1:0]  LAST_TAP    = FILT_AW'(FILT_LEN - 1);
  localparam logic [IDX_W-1:0]    LAST_WIN    = IDX_W'(N_OUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAC  = 3'd1;
`ifdef PSUM_IN_EN
  localparam logic [2:0] S_PSIN = 3'd2;
`endif
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]          state;
  logic [PSUM_W-1:0]   acc;
  logic [IDX_W-1:0]    win;
  logic [FILT_AW-1:0]  tap;

  logic [DATA_W-1:0]   filt_mem  [FILT_LEN];
  logic [DATA_W-1:0]   ifmap_mem [IFMAP_LEN];

  logic                idle;
  logic                filt_we;
  logic                ifmap_we;
  logic [IFMAP_AW-1:0] tap_addr;
  logic [PROD_W-1:0]   prod;
  logic [PSUM_W-1:0]   mac_sum;

  function automatic logic [PSUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                input logic [SUM_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = a + b;
    return (s > PSUM_MAX) ? PSUM_MAX[PSUM_W-1:0] : s[PSUM_W-1:0];
  endfunction

  assign idle = (state == S_IDLE);

  // Out-of-range addresses still handshake (ready is 1) but never write.
  assign filt_we  = bus.filt_valid  && idle && ({1'b0, bus.filt_addr}  < FILT_DEPTH);
  assign ifmap_we = bus.ifmap_valid && idle && ({1'b0, bus.ifmap_addr} < IFMAP_DEPTH);

  assign tap_addr = IFMAP_AW'(32'(win) * STRIDE + 32'(tap));
  assign prod     = PROD_W'(filt_mem[tap]) * PROD_W'(ifmap_mem[tap_addr]);
  assign mac_sum  = sat_add(SUM_W'(acc), SUM_W'(prod));

  // Coefficient and ifmap storage; cleared by reset, otherwise kept across runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FILT_LEN; k++)  filt_mem[k]  <= '0;
      for (int k = 0; k < IFMAP_LEN; k++) ifmap_mem[k] <= '0;
    end else begin
      if (filt_we)  filt_mem[bus.filt_addr]   <= bus.filt_data;
      if (ifmap_we) ifmap_mem[bus.ifmap_addr] <= bus.ifmap_data;
    end
  end

  // Control FSM. A write and a start in the same idle cycle both land at the
  // same edge, so the first MAC cycle already reads the freshly written value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      win   <= '0;
      tap   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_MAC;
            acc   <= '0;
            win   <= '0;
            tap   <= '0;
          end
        end
        S_MAC: begin
          acc <= mac_sum;
          if (tap == LAST_TAP) begin
            tap <= '0;
`ifdef PSUM_IN_EN
            state <= S_PSIN;
`else
            state <= S_EMIT;
`endif
          end else begin
            tap <= tap + 1'b1;
          end
        end
`ifdef PSUM_IN_EN
        S_PSIN: begin
          if (psum_in_valid) begin
            acc   <= sat_add(SUM_W'(acc), SUM_W'(psum_in_data));
            state <= S_EMIT;
          end
        end
`endif
        S_EMIT: begin
          // acc and win are frozen here, which keeps the stream stable while stalled.
          if (bus.psum_ready) begin
            if (win == LAST_WIN) begin
              state <= S_FIN;
            end else begin
              win   <= win + 1'b1;
              tap   <= '0;
              acc   <= '0;
              state <= S_MAC;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.filt_ready  = idle;
  assign bus.ifmap_ready = idle;

  assign bus.psum_valid  = (state == S_EMIT);
  assign bus.psum_data   = (state == S_EMIT) ? acc : '0;
  assign bus.psum_idx    = (state == S_EMIT) ? win : '0;

  assign done = (state == S_FIN);
`ifdef PSUM_IN_EN
  assign psum_in_ready = (state == S_PSIN);
  assign busy = (state == S_MAC) || (state == S_PSIN) || (state == S_EMIT);
`else
  assign busy = (state == S_MAC) || (state == S_EMIT);
`endif

endmodule

// File: tb/tb_conv1d_pe.sv
// tb/tb_conv1d_pe.sv - self-checking bench for conv1d_pe

module tb_conv1d_pe;

  localparam int DATA_W    = 4;
  localparam int IFMAP_LEN = 5;
  localparam int FILT_LEN  = 3;
  localparam int STRIDE    = 1;
  localparam int PSUM_W    = 8;
  localparam int N_OUT     = (IFMAP_LEN - FILT_LEN) / STRIDE + 1;
  localparam int FILT_AW   = 2;
  localparam int IFMAP_AW  = 3;
  localparam int IDX_W     = 2;
  localparam int PMAX      = (1 << PSUM_W) - 1;
`ifdef PSUM_IN_EN
  localparam int EXP_LAT   = FILT_LEN + 2;
  localparam int PIN_VAL   = 100;
`else
  localparam int EXP_LAT   = FILT_LEN + 1;
  localparam int PIN_VAL   = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
`ifdef PSUM_IN_EN
  logic              psum_in_valid;
  logic              psum_in_ready;
  logic [PSUM_W-1:0] psum_in_data;
`endif

  conv1d_pe_if #(.DATA_W(DATA_W), .PSUM_W(PSUM_W), .FILT_AW(FILT_AW),
                 .IFMAP_AW(IFMAP_AW), .IDX_W(IDX_W)) bus ();

  conv1d_pe #(.DATA_W(DATA_W), .IFMAP_LEN(IFMAP_LEN), .FILT_LEN(FILT_LEN),
              .STRIDE(STRIDE), .PSUM_W(PSUM_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
`ifdef PSUM_IN_EN
    .psum_in_valid (psum_in_valid),
    .psum_in_ready (psum_in_ready),
    .psum_in_data  (psum_in_data),
`endif
    .bus           (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int f_m [FILT_LEN];
  int x_m [IFMAP_LEN];
  int got_data [N_OUT];
  int got_idx  [N_OUT];
  int n_got;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: windowed dot product plus upstream psum, clipped at the psum maximum.
  // All terms are non-negative, so clipping the final sum equals per-step saturation.
  function automatic int exp_psum(input int k);
    int s;
    s = PIN_VAL;
    for (int t = 0; t < FILT_LEN; t++) s += f_m[t] * x_m[k*STRIDE + t];
    return (s > PMAX) ? PMAX : s;
  endfunction

  task automatic wr_filt(input int addr, input int data);
    bus.filt_valid = 1'b1;
    bus.filt_addr  = FILT_AW'(addr);
    bus.filt_data  = DATA_W'(data);
    @(posedge clk); #1;
    bus.filt_valid = 1'b0;
    if (addr < FILT_LEN) f_m[addr] = data;
  endtask

  task automatic wr_ifmap(input int addr, input int data);
    bus.ifmap_valid = 1'b1;
    bus.ifmap_addr  = IFMAP_AW'(addr);
    bus.ifmap_data  = DATA_W'(data);
    @(posedge clk); #1;
    bus.ifmap_valid = 1'b0;
    if (addr < IFMAP_LEN) x_m[addr] = data;
  endtask

  task automatic load(input int f[FILT_LEN], input int x[IFMAP_LEN]);
    for (int a = 0; a < FILT_LEN; a++)  wr_filt(a, f[a]);
    for (int a = 0; a < IFMAP_LEN; a++) wr_ifmap(a, x[a]);
  endtask

  task automatic do_run(input int stall_idx, input int stall_n, input bit busy_poke,
                        input bit wr_start, input int wr_addr, input int wr_data);
    int lat;
    int stalled;
    int budget;
    n_got = 0;
    for (int k = 0; k < N_OUT; k++) begin got_data[k] = -1; got_idx[k] = -1; end
    start = 1'b1;
    if (wr_start) begin
      bus.filt_valid = 1'b1;
      bus.filt_addr  = FILT_AW'(wr_addr);
      bus.filt_data  = DATA_W'(wr_data);
      if (wr_addr < FILT_LEN) f_m[wr_addr] = wr_data;
    end
    @(posedge clk); #1;
    start = 1'b0;
    bus.filt_valid = 1'b0;
    lat = 1;
    check("busy_after_start", busy, 1);
    if (busy_poke) begin
      check("filt_ready_busy", bus.filt_ready, 0);
      check("ifmap_ready_busy", bus.ifmap_ready, 0);
      bus.filt_valid  = 1'b1; bus.filt_addr  = '0; bus.filt_data  = 4'd9;
      bus.ifmap_valid = 1'b1; bus.ifmap_addr = '0; bus.ifmap_data = 4'd9;
      start = 1'b1;
      @(posedge clk); #1;
      bus.filt_valid = 1'b0; bus.ifmap_valid = 1'b0; start = 1'b0;
      lat++;
    end
    while (!bus.psum_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_valid_latency", lat, EXP_LAT);
    stalled = 0;
    budget  = 0;
    while (n_got < N_OUT && budget < 200) begin
      if (bus.psum_valid) begin
        if (int'(bus.psum_idx) == stall_idx && stalled < stall_n) begin
          bus.psum_ready = 1'b0;
          stalled++;
          check("stall_hold_data", bus.psum_data, exp_psum(stall_idx));
          check("stall_hold_idx", bus.psum_idx, stall_idx);
        end else begin
          bus.psum_ready = 1'b1;
          got_data[n_got] = int'(bus.psum_data);
          got_idx[n_got]  = int'(bus.psum_idx);
          n_got++;
        end
      end else begin
        bus.psum_ready = 1'b1;
      end
      @(posedge clk); #1;
      budget++;
    end
    bus.psum_ready = 1'b1;
    check("psum_count", n_got, N_OUT);
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("valid_at_done", bus.psum_valid, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    for (int k = 0; k < N_OUT; k++) begin
      check("psum_data", got_data[k], exp_psum(k));
      check("psum_idx", got_idx[k], k);
    end
  endtask

  initial begin
    int f_base [FILT_LEN];
    int x_base [IFMAP_LEN];
    int f_full [FILT_LEN];
    int x_full [IFMAP_LEN];
    int cnt;
    bit saw;

    f_base = '{1, 2, 3};
    x_base = '{1, 2, 3, 4, 5};
    f_full = '{15, 15, 15};
    x_full = '{15, 15, 15, 15, 15};

    rst = 1'b1; start = 1'b0;
    bus.filt_valid = 1'b0;  bus.filt_addr = '0;  bus.filt_data = '0;
    bus.ifmap_valid = 1'b0; bus.ifmap_addr = '0; bus.ifmap_data = '0;
    bus.psum_ready = 1'b1;
`ifdef PSUM_IN_EN
    psum_in_valid = 1'b1;
    psum_in_data  = PSUM_W'(PIN_VAL);
`endif
    for (int k = 0; k < FILT_LEN; k++)  f_m[k] = 0;
    for (int k = 0; k < IFMAP_LEN; k++) x_m[k] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_psum_valid", bus.psum_valid, 0);
    check("rst_psum_data", bus.psum_data, 0);
    check("rst_psum_idx", bus.psum_idx, 0);
    check("rst_filt_ready", bus.filt_ready, 1);
    check("rst_ifmap_ready", bus.ifmap_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_filt_ready", bus.filt_ready, 1);
    check("idle_busy", busy, 0);

    // Basic run: 14, 20, 26
    load(f_base, x_base);
    do_run(-1, 0, 1'b0, 1'b0, 0, 0);
    check("basic_psum0", got_data[0], 14 + PIN_VAL);
    check("basic_psum1", got_data[1], 20 + PIN_VAL);
    check("basic_psum2", got_data[2], 26 + PIN_VAL);

    // Back-pressure on window 1 for 5 cycles
    do_run(1, 5, 1'b0, 1'b0, 0, 0);
    check("stall_psum1", got_data[1], 20 + PIN_VAL);

    // Saturation
    load(f_full, x_full);
    do_run(-1, 0, 1'b0, 1'b0, 0, 0);
    check("sat_psum0", got_data[0], PMAX);

    // Out-of-range write ignored; writes during busy not taken
    load(f_base, x_base);
    wr_filt(3, 7);
    do_run(-1, 0, 1'b1, 1'b0, 0, 0);
    do_run(-1, 0, 1'b0, 1'b0, 0, 0);
    check("rerun_psum0", got_data[0], 14 + PIN_VAL);
    check("rerun_psum2", got_data[2], 26 + PIN_VAL);

    // Write and start in the same cycle: new value is used
    do_run(-1, 0, 1'b0, 1'b1, 0, 5);

    // Randomized contents, including out-of-range ifmap writes
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < FILT_LEN; a++)  wr_filt(a, int'($urandom_range(0, 15)));
      for (int a = 0; a < IFMAP_LEN; a++) wr_ifmap(a, int'($urandom_range(0, 15)));
      wr_ifmap(int'($urandom_range(IFMAP_LEN, 7)), int'($urandom_range(0, 15)));
      do_run(int'($urandom_range(0, N_OUT - 1)), int'($urandom_range(0, 4)), 1'b0, 1'b0, 0, 0);
    end

    // Reset one cycle after the first psum handshake
    load(f_base, x_base);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (!bus.psum_valid && cnt < 50) begin @(posedge clk); #1; cnt++; end
    check("midrst_first_valid", bus.psum_valid, 1);
    bus.psum_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_psum_valid", bus.psum_valid, 0);
    check("midrst_psum_data", bus.psum_data, 0);
    check("midrst_filt_ready", bus.filt_ready, 1);
    rst = 1'b0;
    for (int k = 0; k < FILT_LEN; k++)  f_m[k] = 0;
    for (int k = 0; k < IFMAP_LEN; k++) x_m[k] = 0;
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || bus.psum_valid) saw = 1'b1;
    end
    check("midrst_silent", saw, 0);
    do_run(-1, 0, 1'b0, 1'b0, 0, 0);
    check("zeroed_psum0", got_data[0], PIN_VAL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
